// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: oversamples the async SPI pins on the system clock,
// deserialises fixed-width frames into a one-entry valid/ready buffer and shifts a response out.
module spi_frame_rx #(
    parameter int unsigned FRAME_W = 10,
    parameter int unsigned CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               cs,
    input  logic               mosi,
    output logic               miso,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_load,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               busy,
    output logic               overrun,
    output logic               frame_err
);

    typedef enum logic [1:0] {StIdle, StActive, StWaitDesel} state_e;

    state_e             state;
    logic               sclk_s1, sclk_s2, sclk_d;
    logic               cs_s1, cs_s2, cs_d;
    logic               mosi_s1, mosi_s2;
    logic [1:0]         settle;
    logic               armed;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] tx_shift;
    logic [FRAME_W-1:0] rx_shift;
    logic [CNT_W-1:0]   count;
    logic               done;

    logic               sclk_rise, sclk_fall;
    logic               cs_rise, cs_fall;
    logic [FRAME_W-1:0] tx_first;

    // A cs rise is honoured only after cs has been seen low on a filled synchroniser, so a
    // reset taken while cs is held high cannot join a frame mid-stream.
    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign cs_rise   = armed & cs_s2 & ~cs_d;
    assign cs_fall   = ~cs_s2 & cs_d;
    assign tx_first  = tx_load ? tx_data : shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_d    <= 1'b0;
            cs_s1     <= 1'b0;
            cs_s2     <= 1'b0;
            cs_d      <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            settle    <= 2'd0;
            armed     <= 1'b0;
            shadow    <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            count     <= '0;
            done      <= 1'b0;
            miso      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;

            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd3 && !cs_s2) begin
                armed <= 1'b1;
            end

            overrun   <= 1'b0;
            frame_err <= 1'b0;
            done      <= 1'b0;

            if (tx_load) begin
                shadow <= tx_data;
            end

            // Hand the completed frame to the buffer one cycle after the last bit lands.
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        tx_shift <= tx_first;
                        miso     <= tx_first[FRAME_W-1];
                        count    <= '0;
                        state    <= StActive;
                        busy     <= 1'b1;
                    end
                end

                StActive: begin
                    if (cs_fall) begin
                        if (count != '0) begin
                            frame_err <= 1'b1;
                        end
                        miso  <= 1'b0;
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s2};
                        count    <= count + CNT_W'(1);
                        if (count == CNT_W'(FRAME_W - 1)) begin
                            done  <= 1'b1;
                            miso  <= 1'b0;
                            state <= StWaitDesel;
                            busy  <= 1'b0;
                        end
                    end else if (sclk_fall) begin
                        tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
                        miso     <= tx_shift[FRAME_W-2];
                    end
                end

                StWaitDesel: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    miso  <= 1'b0;
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
